muldiv_unit: RTL and testbench

Multi-cycle multiply/divide unit owning the HI/LO registers; sits beside the ALU in the E stage. It decodes `IR_E`, starts `mult`/`multu`/`div`/`divu` with the E-stage operands already resolved by the forwarding unit, and writes the results to HI/LO after a fixed latency. It services `mthi`/`mtlo` and supplies the `mfhi`/`mflo` result value that the forwarding paths carry downstream. It also raises a D-stage stall whenever an HI/LO-class instruction would collide with an in-flight operation.

---
 rtl/md_pkg.sv | 30 +++
 rtl/muldiv_unit.sv | 154 +++++++++++++++
 tb/tb_muldiv_unit.sv | 272 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/md_pkg.sv
// Shared definitions for the HI/LO multiply/divide unit: instruction
// encodings, FSM state type and default operation latencies.
package md_pkg;

    localparam logic [5:0] OP_RTYPE = 6'b000000;

    localparam logic [5:0] F_MULT  = 6'b011000;
    localparam logic [5:0] F_MULTU = 6'b011001;
    localparam logic [5:0] F_DIV   = 6'b011010;
    localparam logic [5:0] F_DIVU  = 6'b011011;
    localparam logic [5:0] F_MTHI  = 6'b010001;
    localparam logic [5:0] F_MTLO  = 6'b010011;
    localparam logic [5:0] F_MFHI  = 6'b010000;
    localparam logic [5:0] F_MFLO  = 6'b010010;

    // Every funct that reads or writes HI/LO; a D-stage hit stalls while busy.
    localparam int NUM_HILO_FUNCTS = 8;
    localparam logic [5:0] HILO_FUNCTS [NUM_HILO_FUNCTS] = '{
        F_MULT, F_MULTU, F_DIV, F_DIVU, F_MTHI, F_MTLO, F_MFHI, F_MFLO
    };

    localparam int DEF_MULT_CYCLES = 5;
    localparam int DEF_DIV_CYCLES  = 10;

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } md_state_e;

endpackage

// File: rtl/muldiv_unit.sv
// Multi-cycle multiply/divide unit owning HI/LO. The result is computed
// combinationally at start, parked in pending registers and committed to
// HI/LO after a fixed latency so software sees the usual multi-cycle timing.
module muldiv_unit
    import md_pkg::*;
#(
    parameter int MULT_CYCLES = DEF_MULT_CYCLES,
    parameter int DIV_CYCLES  = DEF_DIV_CYCLES
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] IR_D,
    input  logic [31:0] IR_E,
    input  logic [31:0] RS_E,
    input  logic [31:0] RT_E,
    input  logic        en,
    output logic        start,
    output logic        busy,
    output logic        md_stall,
    output logic [31:0] HI,
    output logic [31:0] LO,
    output logic [31:0] MD_OUT
);

    localparam int MAX_CYCLES = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
    localparam int CW         = $clog2(MAX_CYCLES + 1);

    md_state_e     state_reg, state_next;
    logic [CW-1:0] cnt_reg, cnt_next;
    logic [31:0]   hi_reg, lo_reg;
    logic [31:0]   phi_reg, plo_reg;
    logic          pzero_reg;
    logic          commit;

    // ---------------- decode ----------------
    logic [5:0] funct_e, funct_d;
    logic       rtype_e, rtype_d;
    logic       is_mul_e, is_div_e, is_md_e;
    logic       is_mthi_e, is_mtlo_e, is_mfhi_e, is_mflo_e;
    logic [NUM_HILO_FUNCTS-1:0] hit_d;
    logic       hilo_d;
    logic       unused_ir;

    assign funct_e   = IR_E[5:0];
    assign funct_d   = IR_D[5:0];
    assign rtype_e   = (IR_E[31:26] == OP_RTYPE);
    assign rtype_d   = (IR_D[31:26] == OP_RTYPE);
    assign is_mul_e  = rtype_e & ((funct_e == F_MULT) | (funct_e == F_MULTU));
    assign is_div_e  = rtype_e & ((funct_e == F_DIV)  | (funct_e == F_DIVU));
    assign is_md_e   = is_mul_e | is_div_e;
    assign is_mthi_e = rtype_e & (funct_e == F_MTHI);
    assign is_mtlo_e = rtype_e & (funct_e == F_MTLO);
    assign is_mfhi_e = rtype_e & (funct_e == F_MFHI);
    assign is_mflo_e = rtype_e & (funct_e == F_MFLO);
    assign unused_ir = ^{IR_E[25:6], IR_D[25:6]};

    genvar gi;
    generate
        for (gi = 0; gi < NUM_HILO_FUNCTS; gi++) begin : g_hilo_match
            assign hit_d[gi] = (funct_d == HILO_FUNCTS[gi]);
        end
    endgenerate
    assign hilo_d = rtype_d & (|hit_d);

    // ---------------- arithmetic ----------------
    // Even functs (MULT, DIV) are the signed variants.
    logic        signed_op;
    logic [63:0] ext_rs, ext_rt, prod;
    logic        neg_rs, neg_rt, div_zero;
    logic [31:0] mag_rs, mag_rt, mag_rt_safe, q_mag, r_mag, quot, rem;

    assign signed_op = ~funct_e[0];
    assign ext_rs    = {(signed_op ? {32{RS_E[31]}} : 32'h0), RS_E};
    assign ext_rt    = {(signed_op ? {32{RT_E[31]}} : 32'h0), RT_E};
    assign prod      = ext_rs * ext_rt;

    // Divide on magnitudes, then restore signs: quotient truncates toward
    // zero, remainder follows the dividend. 0x80000000 / -1 falls out as
    // 0x80000000 rem 0 without a special case.
    assign neg_rs      = signed_op & RS_E[31];
    assign neg_rt      = signed_op & RT_E[31];
    assign mag_rs      = neg_rs ? (~RS_E + 32'd1) : RS_E;
    assign mag_rt      = neg_rt ? (~RT_E + 32'd1) : RT_E;
    assign div_zero    = (RT_E == 32'h0);
    assign mag_rt_safe = div_zero ? 32'd1 : mag_rt;
    assign q_mag       = mag_rs / mag_rt_safe;
    assign r_mag       = mag_rs % mag_rt_safe;
    assign quot        = (neg_rs ^ neg_rt) ? (~q_mag + 32'd1) : q_mag;
    assign rem         = neg_rs ? (~r_mag + 32'd1) : r_mag;

    // ---------------- control ----------------
    assign start    = en & (state_reg == IDLE) & is_md_e;
    assign busy     = (state_reg == RUN);
    assign md_stall = hilo_d & (start | busy);

    // Next-state / countdown logic; commit fires on the final busy cycle.
    always_comb begin
        state_next = state_reg;
        cnt_next   = cnt_reg;
        commit     = 1'b0;
        case (state_reg)
            IDLE: begin
                if (start) begin
                    state_next = RUN;
                    cnt_next   = is_mul_e ? CW'(MULT_CYCLES) : CW'(DIV_CYCLES);
                end
            end
            RUN: begin
                cnt_next = cnt_reg - CW'(1);
                if (cnt_reg == CW'(1)) begin
                    state_next = IDLE;
                    commit     = 1'b1;
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // FSM, pending result and HI/LO registers. Operations arriving while
    // RUN are ignored, so a protocol slip cannot corrupt HI/LO.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_reg <= IDLE;
            cnt_reg   <= '0;
            hi_reg    <= 32'h0;
            lo_reg    <= 32'h0;
            phi_reg   <= 32'h0;
            plo_reg   <= 32'h0;
            pzero_reg <= 1'b0;
        end else begin
            state_reg <= state_next;
            cnt_reg   <= cnt_next;
            if (start) begin
                phi_reg   <= is_mul_e ? prod[63:32] : rem;
                plo_reg   <= is_mul_e ? prod[31:0]  : quot;
                pzero_reg <= is_div_e & div_zero;
            end
            if (commit && !pzero_reg) begin
                hi_reg <= phi_reg;
                lo_reg <= plo_reg;
            end else if (en && state_reg == IDLE) begin
                if (is_mthi_e) hi_reg <= RS_E;
                if (is_mtlo_e) lo_reg <= RS_E;
            end
        end
    end

    assign HI     = hi_reg;
    assign LO     = lo_reg;
    assign MD_OUT = is_mfhi_e ? hi_reg : (is_mflo_e ? lo_reg : 32'h0);

endmodule

// File: tb/tb_muldiv_unit.sv
// Randomized self-checking bench for muldiv_unit with a behavioural
// HI/LO reference model computed from plain 64-bit arithmetic.
module tb_muldiv_unit;

    localparam int NMUL = 5;
    localparam int NDIV = 10;

    localparam logic [5:0] FM_MULT  = 6'b011000;
    localparam logic [5:0] FM_MULTU = 6'b011001;
    localparam logic [5:0] FM_DIV   = 6'b011010;
    localparam logic [5:0] FM_DIVU  = 6'b011011;
    localparam logic [5:0] FM_MTHI  = 6'b010001;
    localparam logic [5:0] FM_MTLO  = 6'b010011;
    localparam logic [5:0] FM_MFHI  = 6'b010000;
    localparam logic [5:0] FM_MFLO  = 6'b010010;
    localparam logic [5:0] FM_ADDU  = 6'b100001;

    logic        clk = 1'b0;
    logic        reset;
    logic [31:0] IR_D, IR_E, RS_E, RT_E;
    logic        en;
    logic        start, busy, md_stall;
    logic [31:0] HI, LO, MD_OUT;

    int total = 0;
    int bad   = 0;

    logic [31:0] hi_m = 32'h0;
    logic [31:0] lo_m = 32'h0;

    muldiv_unit #(.MULT_CYCLES(NMUL), .DIV_CYCLES(NDIV)) dut (
        .clk(clk), .reset(reset), .IR_D(IR_D), .IR_E(IR_E), .RS_E(RS_E),
        .RT_E(RT_E), .en(en), .start(start), .busy(busy), .md_stall(md_stall),
        .HI(HI), .LO(LO), .MD_OUT(MD_OUT)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout, want finish");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] want);
        total++;
        if (got !== want) begin
            bad++;
            $display("FAIL %s: got %08h want %08h", tag, got, want);
        end
    endtask

    function automatic logic [31:0] rinstr(input logic [5:0] f);
        logic [19:0] mid;
        mid = 20'($urandom);
        return {6'b000000, mid, f};
    endfunction

    // Advance to just after the next rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Reference result of a mult/div op, from plain wide arithmetic.
    task automatic model(input logic [5:0] f, input logic [31:0] rs, input logic [31:0] rt,
                         output logic [31:0] h, output logic [31:0] l);
        longint      a, b, p, q, r;
        logic [63:0] u;
        h = hi_m;
        l = lo_m;
        case (f)
            FM_MULT: begin
                a = longint'($signed(rs));
                b = longint'($signed(rt));
                p = a * b;
                h = p[63:32];
                l = p[31:0];
            end
            FM_MULTU: begin
                u = {32'h0, rs} * {32'h0, rt};
                h = u[63:32];
                l = u[31:0];
            end
            FM_DIV: if (rt != 0) begin
                a = longint'($signed(rs));
                b = longint'($signed(rt));
                q = a / b;
                r = a % b;
                h = r[31:0];
                l = q[31:0];
            end
            FM_DIVU: if (rt != 0) begin
                h = rs % rt;
                l = rs / rt;
            end
            default: ;
        endcase
    endtask

    // Issue one mult/div op in E and follow it to completion. IR_D holds
    // either a HI/LO reader (must stall) or an unrelated op (must not).
    // Optionally a HI/LO op is illegally placed in E while busy.
    task automatic run_op(input logic [5:0] f, input logic [31:0] rs, input logic [31:0] rt,
                          input bit dep_d, input bit violate);
        int          n;
        logic [31:0] eh, el;
        logic        want_stall;
        n = (f == FM_MULT || f == FM_MULTU) ? NMUL : NDIV;
        model(f, rs, rt, eh, el);
        want_stall = dep_d;
        IR_D = rinstr(dep_d ? FM_MFLO : FM_ADDU);
        IR_E = rinstr(f);
        RS_E = rs;
        RT_E = rt;
        en   = 1'b1;
        #1;
        chk("start", {31'h0, start}, 32'd1);
        chk("stall_c0", {31'h0, md_stall}, {31'h0, want_stall});
        chk("busy_c0", {31'h0, busy}, 32'd0);
        for (int c = 1; c <= n; c++) begin
            tick();
            IR_E = rinstr(FM_ADDU);
            en   = 1'($urandom);
            RS_E = $urandom;
            if (violate && c == 2) begin
                IR_E = rinstr(($urandom % 2) ? FM_MTHI : FM_MULT);
                en   = 1'b1;
            end
            #1;
            chk("busy_run", {31'h0, busy}, 32'd1);
            chk("start_run", {31'h0, start}, 32'd0);
            chk("stall_run", {31'h0, md_stall}, {31'h0, want_stall});
            chk("hi_hold", HI, hi_m);
            chk("lo_hold", LO, lo_m);
        end
        tick();
        IR_E = rinstr(FM_MFLO);
        en   = 1'b1;
        #1;
        hi_m = eh;
        lo_m = el;
        chk("busy_done", {31'h0, busy}, 32'd0);
        chk("stall_done", {31'h0, md_stall}, 32'd0);
        chk("hi_done", HI, hi_m);
        chk("lo_done", LO, lo_m);
        chk("mflo_out", MD_OUT, lo_m);
        $display("op f=%06b rs=%08h rt=%08h -> hi=%08h lo=%08h", f, rs, rt, HI, LO);
        IR_E = rinstr(FM_ADDU);
    endtask

    // Single-cycle mt/mf/nop transaction in E (unit idle).
    task automatic run_simple(input logic [5:0] f, input logic [31:0] rs, input logic en_v);
        IR_D = rinstr(FM_MFHI);
        IR_E = rinstr(f);
        RS_E = rs;
        en   = en_v;
        #1;
        chk("stall_simple", {31'h0, md_stall}, 32'd0);
        chk("start_simple", {31'h0, start}, 32'd0);
        if (f == FM_MFHI)      chk("mfhi_out", MD_OUT, hi_m);
        else if (f == FM_MFLO) chk("mflo_out", MD_OUT, lo_m);
        else                   chk("md_out_zero", MD_OUT, 32'h0);
        tick();
        if (en_v && f == FM_MTHI) hi_m = rs;
        if (en_v && f == FM_MTLO) lo_m = rs;
        chk("hi_simple", HI, hi_m);
        chk("lo_simple", LO, lo_m);
        $display("op f=%06b rs=%08h en=%0d -> hi=%08h lo=%08h", f, rs, en_v, HI, LO);
        IR_E = rinstr(FM_ADDU);
    endtask

    initial begin
        logic [5:0]  fsel [8];
        logic [5:0]  f;
        logic [31:0] rs, rt;
        fsel = '{FM_MULT, FM_MULTU, FM_DIV, FM_DIVU, FM_MTHI, FM_MTLO, FM_MFHI, FM_MFLO};

        reset = 1'b1;
        IR_D  = 32'h0;
        IR_E  = 32'h0;
        RS_E  = 32'h0;
        RT_E  = 32'h0;
        en    = 1'b0;
        tick();
        tick();
        chk("rst_busy", {31'h0, busy}, 32'd0);
        chk("rst_hi", HI, 32'h0);
        chk("rst_lo", LO, 32'h0);
        reset = 1'b0;
        tick();

        // Directed cases with literal expectations.
        run_op(FM_MULT, 32'hFFFFFFFE, 32'd3, 1'b1, 1'b0);
        chk("mult_hi_lit", HI, 32'hFFFFFFFF);
        chk("mult_lo_lit", LO, 32'hFFFFFFFA);
        run_op(FM_MULTU, 32'hFFFFFFFE, 32'd3, 1'b1, 1'b0);
        chk("multu_hi_lit", HI, 32'h00000002);
        chk("multu_lo_lit", LO, 32'hFFFFFFFA);
        run_op(FM_DIV, 32'hFFFFFFF9, 32'd2, 1'b1, 1'b0);
        chk("div_hi_lit", HI, 32'hFFFFFFFF);
        chk("div_lo_lit", LO, 32'hFFFFFFFD);
        run_op(FM_DIV, 32'hFFFFFFF9, 32'd0, 1'b1, 1'b0);
        chk("div0_hi_lit", HI, 32'hFFFFFFFF);
        chk("div0_lo_lit", LO, 32'hFFFFFFFD);
        run_op(FM_DIV, 32'h80000000, 32'hFFFFFFFF, 1'b0, 1'b0);
        chk("ovf_hi_lit", HI, 32'h0);
        chk("ovf_lo_lit", LO, 32'h80000000);
        run_simple(FM_MTHI, 32'h12345678, 1'b1);
        run_simple(FM_MFHI, $urandom, 1'b1);
        chk("mthi_lit", HI, 32'h12345678);
        run_simple(FM_MTLO, 32'hCAFEF00D, 1'b0);
        run_simple(FM_ADDU, $urandom, 1'b1);

        // Start with en low: nothing happens.
        IR_E = rinstr(FM_MULT);
        RS_E = 32'd7;
        RT_E = 32'd9;
        en   = 1'b0;
        #1;
        chk("noen_start", {31'h0, start}, 32'd0);
        tick();
        chk("noen_busy", {31'h0, busy}, 32'd0);
        chk("noen_lo", LO, lo_m);

        // Randomized traffic.
        for (int i = 0; i < 60; i++) begin
            f  = fsel[$urandom_range(0, 7)];
            rs = $urandom;
            rt = $urandom;
            case ($urandom_range(0, 7))
                0: rt = 32'h0;
                1: begin rs = 32'h80000000; rt = 32'hFFFFFFFF; end
                2: rt = 32'($urandom_range(1, 9));
                default: ;
            endcase
            if (f == FM_MTHI || f == FM_MTLO || f == FM_MFHI || f == FM_MFLO)
                run_simple(f, rs, 1'($urandom));
            else
                run_op(f, rs, rt, 1'($urandom), ($urandom_range(0, 3) == 0));
        end

        // Asynchronous reset in cycle 3 of a mult.
        IR_D = rinstr(FM_ADDU);
        IR_E = rinstr(FM_MULT);
        RS_E = 32'hFFFFFFFF;
        RT_E = 32'h00000005;
        en   = 1'b1;
        tick();
        IR_E = rinstr(FM_ADDU);
        tick();
        tick();
        reset = 1'b1;
        #1;
        hi_m = 32'h0;
        lo_m = 32'h0;
        chk("arst_busy", {31'h0, busy}, 32'd0);
        chk("arst_hi", HI, 32'h0);
        chk("arst_lo", LO, 32'h0);
        tick();
        reset = 1'b0;
        for (int c = 0; c < NMUL + 2; c++) tick();
        chk("post_rst_busy", {31'h0, busy}, 32'd0);
        chk("post_rst_hi", HI, 32'h0);
        chk("post_rst_lo", LO, 32'h0);
        run_op(FM_DIVU, 32'd100, 32'd7, 1'b1, 1'b0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
